div_client: RTL and testbench
=============================

Name: div_client

Overview:
- Bus initiator that offloads 32-bit divides to the memory-mapped divider peripheral on the c_* bus.
- Accepts a request (dividend, divisor, signedness) on a valid/ready stream in the fclk domain and runs this access sequence: program operands, start, poll busy, read quotient and remainder, clear start.
- Returns the result on a valid/ready response stream.
- Sits between a CPU M-extension/accelerator datapath and the divider; the bus clock c_clk is tied to fclk at system level.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the divider register block (A +0x00, B +0x04, Q +0x08, R +0x0C, CTL +0x10).
- START_WAIT, 2, idle cycles after the CTL start write before the first busy poll (covers the peripheral's start latency).
- POLL_LIMIT, 64, maximum busy polls before the request is aborted with rsp_err.

Ports:
- fclk  in  1  clock; all logic rising-edge
- frstb  in  1  async active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when high with req_valid
- req_a  in  32  dividend
- req_b  in  32  divisor
- req_uns  in  1  1 = unsigned, 0 = signed
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- rsp_q  out  32  quotient
- rsp_r  out  32  remainder
- rsp_err  out  1  poll timeout; q/r forced 0
- c_valid  out  1  bus access request
- c_ready  in  1  responder completion
- c_write  out  1  1 = write
- c_addr  out  32  byte address
- c_size  out  2  fixed 2'b10 (word)
- c_wdata  out  32  write data
- c_rdata  in  32  read data, valid in the c_ready cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (frstb low, async): state IDLE; c_valid=0; c_write=0; c_addr=0; c_wdata=0; rsp_valid=0; rsp_q=0; rsp_r=0; rsp_err=0; req_ready=0; counters cleared.
- req_ready = (state==IDLE). A handshake latches a, b and uns into internal registers.
- Bus access rules:
  - Raise c_valid with c_addr, c_write and c_wdata stable, all registered.
  - Hold all of them until the edge that samples c_ready=1.
  - Deassert c_valid on that same edge; capture c_rdata on that edge for reads.
  - c_valid must be low for at least one cycle between accesses.
  - Minimum 2 cycles per access. The responder may execute a held access twice; every access in the sequence is idempotent, so this is harmless.
  - c_ready seen while c_valid=0 is ignored.
- States and transitions:
  - IDLE -> WR_A (write a to +0x00)
  - WR_A -> WR_B (write b to +0x04)
  - WR_B -> WR_CTL (write {30'b0, uns, 1'b1} to +0x10)
  - WR_CTL -> WAIT (START_WAIT cycles)
  - WAIT -> POLL (read +0x10)
  - POLL: if rdata[0]=1 and polls < POLL_LIMIT, go to WAIT with a 1-cycle wait; if rdata[0]=0, go to RD_Q; if POLL_LIMIT is reached, set err and go to CLR.
  - RD_Q (read +0x08) -> RD_R (read +0x0C) -> CLR (write {30'b0, uns, 1'b0} to +0x10) -> RESP.
- CLR is always issued, including on timeout, so the peripheral returns to idle.
- RESP: rsp_valid=1; q, r and err are held stable until rsp_ready. The handshake edge clears rsp_valid and goes to IDLE. rsp_ready is ignored outside RESP.
- Poll counter is 7-bit saturating and is cleared on entry to WR_A.
- Results are passed through unmodified. Sign handling belongs to the peripheral; this block does no arithmetic.
- Reset mid-transaction drops c_valid immediately. The responder's own reset governs its state.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined: when the latched b==0, skip the bus entirely and go to RESP on the next cycle with q=32'hFFFF_FFFF, r=a and err=0 (RISC-V divide-by-zero semantics). Zero bus activity is required.
- Undefined: divisor zero takes the normal bus path, and the result is whatever the peripheral returns.

Decomposition:
- Shared package div_pkg holds:
  - register offsets (DIV_A=0x00, DIV_B=0x04, DIV_Q=0x08, DIV_R=0x0C, DIV_CTL=0x10)
  - CTL bit indices (START=0, UNS=1, BUSY=0)
  - state enum for the FSM
- One natural sub-module, bus_init_port: single-access initiator. Inputs: start, write, addr, wdata. Outputs: done, rdata, plus the c_* drive. The FSM sequences it.

Test Plan:
- Signed 100 / 7, responder model with a 33-cycle busy -> rsp_q=14, rsp_r=2, rsp_err=0; bus trace is A, B, CTL=0x1, polls, Q, R, CTL=0x0 in that order.
- Signed -100 / 7 -> rsp_q=0xFFFF_FFF2, rsp_r=0xFFFF_FFFE. Unsigned 0xFFFF_FFFF / 16 (uns=1) -> CTL writes 0x3 then 0x2; rsp_q=0x0FFF_FFFF, rsp_r=0xF.
- Back-to-back identical operands with rsp_ready held low 10 cycles -> rsp_valid and data stable throughout; req_ready stays low until the handshake; second result identical.
- Responder model with busy stuck at 1 -> exactly POLL_LIMIT=64 polls, then CLR write, then rsp_err=1 with q=r=0.
- frstb asserted during POLL -> c_valid=0 and busy=0 asynchronously; after release, a new 20 / 3 request -> q=6, r=2.
- With DIV_ZERO_BYPASS_EN, a=5, b=0 -> no c_valid pulse; rsp_q=0xFFFF_FFFF and rsp_r=5 two cycles after accept.

Source files
------------

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Definitions shared by div_client and its bus access port.
//   - Byte offsets of the divider peripheral's register block
//   - Bit positions inside the CTL register
//   - FSM state encoding for the divide access sequence
//   - Helper that builds a CTL write word
// -----------------------------------------------------------------------------
package div_pkg;

   // Register offsets relative to the block base address
   localparam logic [31:0] DIV_A   = 32'h0000_0000;
   localparam logic [31:0] DIV_B   = 32'h0000_0004;
   localparam logic [31:0] DIV_Q   = 32'h0000_0008;
   localparam logic [31:0] DIV_R   = 32'h0000_000C;
   localparam logic [31:0] DIV_CTL = 32'h0000_0010;

   // CTL bit positions: START on write, BUSY on read share bit 0
   localparam int CTL_START = 0;
   localparam int CTL_UNS   = 1;
   localparam int CTL_BUSY  = 0;

   // Every access on the c_* bus is a 32-bit word
   localparam logic [1:0] C_SIZE_WORD = 2'b10;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_A,
      ST_WR_B,
      ST_WR_CTL,
      ST_WAIT,
      ST_POLL,
      ST_RD_Q,
      ST_RD_R,
      ST_CLR,
      ST_RESP
   } state_t;

   function automatic logic [31:0] ctl_word(input logic uns, input logic start);
      logic [31:0] w;
      w            = '0;
      w[CTL_UNS]   = uns;
      w[CTL_START] = start;
      return w;
   endfunction

endpackage

// File: rtl/bus_init_port.sv
// -----------------------------------------------------------------------------
// bus_init_port
// Single-access initiator for the c_* bus. A request on i_start launches one
// registered access; the port holds it until c_ready, drops c_valid on that
// same edge and pulses o_done for one cycle afterwards.
//
// Ports
//   fclk, frstb        clock, async active-low reset
//   i_start            launch an access (ignored while one is in flight and
//                      in the o_done cycle, which also gives the c_valid gap)
//   i_write            1 = write, 0 = read
//   i_addr, i_wdata    access address / write data
//   o_done             one-cycle pulse after the completing edge
//   o_rdata            read data captured on the completing edge
//   c_valid, c_write, c_addr, c_size, c_wdata   registered bus drive
//   c_ready, c_rdata   responder completion / read data
// -----------------------------------------------------------------------------
module bus_init_port
   import div_pkg::*;
(
   input  logic        fclk,
   input  logic        frstb,
   input  logic        i_start,
   input  logic        i_write,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic        c_valid,
   output logic        c_write,
   output logic [31:0] c_addr,
   output logic [1:0]  c_size,
   output logic [31:0] c_wdata,
   input  logic        c_ready,
   input  logic [31:0] c_rdata
);

   logic        r_valid;
   logic        r_write;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_done;
   logic [31:0] r_rdata;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and the block order cannot create races.
   always_ff @(posedge fclk or negedge frstb) begin
      if (!frstb) begin
         r_valid <= 1'b0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_done  <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_valid) begin
            // c_ready only counts while an access is held
            if (c_ready) begin
               r_valid <= 1'b0;
               r_done  <= 1'b1;
               if (!r_write) r_rdata <= c_rdata;
            end
         end else if (i_start && !r_done) begin
            r_valid <= 1'b1;
            r_write <= i_write;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
         end
      end
   end

   assign o_done  = r_done;
   assign o_rdata = r_rdata;
   assign c_valid = r_valid;
   assign c_write = r_write;
   assign c_addr  = r_addr;
   assign c_wdata = r_wdata;
   assign c_size  = C_SIZE_WORD;

endmodule

// File: rtl/div_client.sv
// -----------------------------------------------------------------------------
// div_client
// Offloads a 32-bit divide to the memory-mapped divider on the c_* bus:
// write A, write B, write CTL start, wait, poll BUSY, read Q and R, clear
// CTL start, then present the result on the response stream. Results pass
// through untouched; the peripheral owns sign handling.
//
// Optional feature macro: DIV_ZERO_BYPASS_EN
//   defined   - a zero divisor skips the bus and returns q=all ones, r=a
//   undefined - a zero divisor goes through the peripheral like any other
//
// Parameters
//   BASE_ADDR   byte base of the divider register block
//   START_WAIT  idle cycles after the start write before the first poll
//   POLL_LIMIT  busy polls allowed before the request ends with rsp_err
//
// Ports
//   fclk, frstb                   clock, async active-low reset
//   req_valid/req_ready           request stream; req_a, req_b, req_uns
//   rsp_valid/rsp_ready           response stream; rsp_q, rsp_r, rsp_err
//   c_valid/c_ready, c_write, c_addr, c_size, c_wdata, c_rdata   bus
//   busy                          high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module div_client
   import div_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          START_WAIT = 2,
   parameter int          POLL_LIMIT = 64
) (
   input  logic        fclk,
   input  logic        frstb,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        req_uns,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_q,
   output logic [31:0] rsp_r,
   output logic        rsp_err,
   output logic        c_valid,
   input  logic        c_ready,
   output logic        c_write,
   output logic [31:0] c_addr,
   output logic [1:0]  c_size,
   output logic [31:0] c_wdata,
   input  logic [31:0] c_rdata,
   output logic        busy
);

   // A zero START_WAIT still spends the one WAIT cycle the state needs
   localparam logic [7:0] START_WAIT_M1 = (START_WAIT > 0) ? 8'(START_WAIT - 1) : 8'd0;

   state_t      r_state;
   state_t      w_next;

   logic [31:0] r_a;
   logic [31:0] r_b;
   logic        r_uns;
   logic [6:0]  r_poll_cnt;
   logic [7:0]  r_wait_cnt;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_q;
   logic [31:0] r_rsp_r;
   logic        r_rsp_err;

   logic        w_start;
   logic        w_write;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic        w_done;
   logic [31:0] w_rdata;
   logic        w_accept;
   logic        w_poll_last;
   logic        w_bypass;

`ifdef DIV_ZERO_BYPASS_EN
   assign w_bypass = (r_b == '0);
`else
   assign w_bypass = 1'b0;
`endif

   assign w_accept    = (r_state == ST_IDLE) && req_valid && r_req_ready;
   // The poll being completed is the POLL_LIMIT-th one
   assign w_poll_last = (int'(r_poll_cnt) + 1) >= POLL_LIMIT;

   bus_init_port u_port (
      .fclk    (fclk),
      .frstb   (frstb),
      .i_start (w_start),
      .i_write (w_write),
      .i_addr  (w_addr),
      .i_wdata (w_wdata),
      .o_done  (w_done),
      .o_rdata (w_rdata),
      .c_valid (c_valid),
      .c_write (c_write),
      .c_addr  (c_addr),
      .c_size  (c_size),
      .c_wdata (c_wdata),
      .c_ready (c_ready),
      .c_rdata (c_rdata)
   );

   always_ff @(posedge fclk or negedge frstb) begin
      if (!frstb) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_write = 1'b0;
      w_addr  = BASE_ADDR + DIV_CTL;
      w_wdata = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next = ST_WR_A;
         end
         ST_WR_A: begin
            if (w_bypass) begin
               w_next = ST_RESP;
            end else begin
               w_start = 1'b1;
               w_write = 1'b1;
               w_addr  = BASE_ADDR + DIV_A;
               w_wdata = r_a;
               if (w_done) w_next = ST_WR_B;
            end
         end
         ST_WR_B: begin
            w_start = 1'b1;
            w_write = 1'b1;
            w_addr  = BASE_ADDR + DIV_B;
            w_wdata = r_b;
            if (w_done) w_next = ST_WR_CTL;
         end
         ST_WR_CTL: begin
            w_start = 1'b1;
            w_write = 1'b1;
            w_wdata = ctl_word(r_uns, 1'b1);
            if (w_done) w_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (r_wait_cnt == '0) w_next = ST_POLL;
         end
         ST_POLL: begin
            w_start = 1'b1;
            if (w_done) begin
               if (!w_rdata[CTL_BUSY]) w_next = ST_RD_Q;
               else if (w_poll_last)   w_next = ST_CLR;
               else                    w_next = ST_WAIT;
            end
         end
         ST_RD_Q: begin
            w_start = 1'b1;
            w_addr  = BASE_ADDR + DIV_Q;
            if (w_done) w_next = ST_RD_R;
         end
         ST_RD_R: begin
            w_start = 1'b1;
            w_addr  = BASE_ADDR + DIV_R;
            if (w_done) w_next = ST_CLR;
         end
         ST_CLR: begin
            // Issued on timeout too, so the peripheral always returns to idle
            w_start = 1'b1;
            w_write = 1'b1;
            w_wdata = ctl_word(r_uns, 1'b0);
            if (w_done) w_next = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge fclk or negedge frstb) begin
      if (!frstb) begin
         r_a         <= '0;
         r_b         <= '0;
         r_uns       <= 1'b0;
         r_poll_cnt  <= '0;
         r_wait_cnt  <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_q     <= '0;
         r_rsp_r     <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_req_ready <= (w_next == ST_IDLE);
         r_rsp_valid <= (w_next == ST_RESP);

         if (w_accept) begin
            r_a        <= req_a;
            r_b        <= req_b;
            r_uns      <= req_uns;
            r_poll_cnt <= '0;
         end else if (r_state == ST_POLL && w_done && r_poll_cnt != '1) begin
            r_poll_cnt <= r_poll_cnt + 7'd1;
         end

         // Long wait after the start write, single cycle between polls
         if (r_state == ST_WR_CTL && w_done)      r_wait_cnt <= START_WAIT_M1;
         else if (r_state == ST_POLL && w_done)   r_wait_cnt <= '0;
         else if (r_state == ST_WAIT && r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - 8'd1;

         case (r_state)
            ST_WR_A: begin
               if (w_bypass) begin
                  r_rsp_q   <= '1;
                  r_rsp_r   <= r_a;
                  r_rsp_err <= 1'b0;
               end
            end
            ST_POLL: begin
               if (w_done && w_rdata[CTL_BUSY] && w_poll_last) begin
                  r_rsp_q   <= '0;
                  r_rsp_r   <= '0;
                  r_rsp_err <= 1'b1;
               end
            end
            ST_RD_Q: begin
               if (w_done) begin
                  r_rsp_q   <= w_rdata;
                  r_rsp_err <= 1'b0;
               end
            end
            ST_RD_R: begin
               if (w_done) r_rsp_r <= w_rdata;
            end
            default: ;
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_q     = r_rsp_q;
   assign rsp_r     = r_rsp_r;
   assign rsp_err   = r_rsp_err;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_div_client.sv
// -----------------------------------------------------------------------------
// tb_div_client
// Drives div_client against a behavioural model of the divider peripheral and
// compares results, bus traces and handshake behaviour against plain
// arithmetic reference values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_client;

   localparam int POLL_LIMIT = 64;

   logic        fclk = 1'b0;
   logic        frstb;
   logic        req_valid, req_ready, req_uns;
   logic [31:0] req_a, req_b;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_q, rsp_r;
   logic        c_valid, c_ready, c_write;
   logic [31:0] c_addr, c_wdata, c_rdata;
   logic [1:0]  c_size;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } acc_t;
   acc_t trace[$];

   // Peripheral model state
   logic [31:0] p_a, p_b, p_q, p_r;
   logic        p_uns;
   int          busy_cnt = 0;
   int          busy_len = 5;
   bit          stuck    = 0;
   bit          saw_valid = 0;

   always #5 fclk = ~fclk;
   always @(posedge fclk) cyc <= cyc + 1;

   div_client #(.BASE_ADDR(32'h0), .START_WAIT(2), .POLL_LIMIT(POLL_LIMIT)) dut (
      .fclk(fclk), .frstb(frstb),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_uns(req_uns),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
      .c_valid(c_valid), .c_ready(c_ready), .c_write(c_write), .c_addr(c_addr), .c_size(c_size),
      .c_wdata(c_wdata), .c_rdata(c_rdata), .busy(busy)
   );

   // RISC-V style divide: truncating, zero divisor and overflow defined
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic uns,
                                   output logic [31:0] q, output logic [31:0] r);
      int sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (uns) begin
         q = a / b; r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a; r = 32'd0;
      end else begin
         q = sa / sb; r = sa % sb;
      end
   endfunction

   // -1 when the recorded trace is the canonical access sequence with
   // 'polls' CTL reads (any number >= 1 when polls < 0); otherwise the index
   // of the first differing entry (or 9999 on a length difference)
   function automatic int trace_mismatch(input logic [31:0] a, input logic [31:0] b,
                                         input logic uns, input int polls);
      acc_t exp[$];
      int   np;
      np = (polls < 0) ? trace.size() - 6 : polls;
      if (np < 1) return 9999;
      exp.push_back('{wr: 1'b1, addr: 32'h00, data: a});
      exp.push_back('{wr: 1'b1, addr: 32'h04, data: b});
      exp.push_back('{wr: 1'b1, addr: 32'h10, data: {30'd0, uns, 1'b1}});
      for (int i = 0; i < np; i++) exp.push_back('{wr: 1'b0, addr: 32'h10, data: 32'd0});
      exp.push_back('{wr: 1'b0, addr: 32'h08, data: 32'd0});
      exp.push_back('{wr: 1'b0, addr: 32'h0C, data: 32'd0});
      exp.push_back('{wr: 1'b1, addr: 32'h10, data: {30'd0, uns, 1'b0}});
      if (exp.size() != trace.size()) return 9999;
      for (int i = 0; i < exp.size(); i++)
         if (trace[i].wr !== exp[i].wr || trace[i].addr !== exp[i].addr || trace[i].data !== exp[i].data)
            return i;
      return -1;
   endfunction

   // Responder: random completion latency, protocol monitor, divider model
   initial begin : responder
      int          lat = 0;
      bit          pv = 0;
      bit          done_now;
      logic        pw;
      logic [31:0] pa, pd, rd;
      c_ready = 1'b0;
      c_rdata = '0;
      forever begin
         @(negedge fclk);
         if (!frstb) begin
            c_ready = 1'b0; pv = 0; lat = 0;
            continue;
         end
         if (busy_cnt > 0) busy_cnt--;
         if (c_valid) saw_valid = 1;
         done_now = c_ready;
         c_ready  = 1'b0;
         if (done_now) begin
            n_checks++;
            if (c_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL bus_gap: c_valid=%b after completion, expected 0", c_valid);
            end
         end else if (pv && c_valid) begin
            n_checks++;
            if ({c_write, c_addr, c_wdata} !== {pw, pa, pd}) begin
               n_fail++;
               $display("FAIL bus_hold: w=%b a=%h d=%h changed from w=%b a=%h d=%h", c_write, c_addr, c_wdata, pw, pa, pd);
            end
         end
         if (c_valid) begin
            n_checks++;
            if (c_size !== 2'b10) begin
               n_fail++;
               $display("FAIL bus_size: c_size=%b expected 10", c_size);
            end
         end
         pv = c_valid; pw = c_write; pa = c_addr; pd = c_wdata;
         if (c_valid && !done_now) begin
            if (lat > 0) begin
               lat--;
            end else begin
               trace.push_back('{wr: c_write, addr: c_addr, data: c_write ? c_wdata : 32'd0});
               rd = 32'd0;
               if (c_write) begin
                  case (c_addr)
                     32'h00: p_a = c_wdata;
                     32'h04: p_b = c_wdata;
                     32'h10: begin
                        p_uns = c_wdata[1];
                        if (c_wdata[0]) begin
                           ref_div(p_a, p_b, p_uns, p_q, p_r);
                           busy_cnt = busy_len;
                        end
                     end
                     default: ;
                  endcase
               end else begin
                  case (c_addr)
                     32'h00: rd = p_a;
                     32'h04: rd = p_b;
                     32'h08: rd = p_q;
                     32'h0C: rd = p_r;
                     32'h10: rd = {30'd0, p_uns, (stuck || busy_cnt > 0)};
                     default: rd = 32'd0;
                  endcase
               end
               c_rdata = rd;
               c_ready = 1'b1;
               lat = $urandom_range(0, 2);
            end
         end
      end
   end

   task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic uns, output int acc_cyc);
      bit got = 0;
      trace.delete();
      saw_valid = 0;
      @(negedge fclk);
      req_a = a; req_b = b; req_uns = uns; req_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (req_ready) begin got = 1; break; end
         @(negedge fclk);
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL req_accept: req_ready=%b after 100 cycles, expected 1", req_ready);
      end
      acc_cyc = cyc;
      @(posedge fclk);
      #1 req_valid = 1'b0;
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic uns,
                         input int hold, input bit early,
                         output logic [31:0] q, output logic [31:0] r, output logic err,
                         output int lat);
      int acc_cyc;
      bit got = 0;
      offer(a, b, uns, acc_cyc);
      rsp_ready = early;
      for (int i = 0; i < 5000; i++) begin
         @(negedge fclk);
         if (rsp_valid) begin got = 1; break; end
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL rsp_timeout: rsp_valid=%b after 5000 cycles, expected 1", rsp_valid);
      end
      lat = cyc - acc_cyc;
      q = rsp_q; r = rsp_r; err = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge fclk);
         n_checks++;
         if ({rsp_valid, rsp_q, rsp_r, rsp_err, req_ready} !== {1'b1, q, r, err, 1'b0}) begin
            n_fail++;
            $display("FAIL rsp_hold: v=%b q=%h r=%h e=%b rdy=%b, expected v=1 q=%h r=%h e=%b rdy=0",
                     rsp_valid, rsp_q, rsp_r, rsp_err, req_ready, q, r, err);
         end
      end
      rsp_ready = 1'b1;
      @(posedge fclk);
      #1 rsp_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rsp_clear: rsp_valid=%b after handshake, expected 0", rsp_valid);
      end
   endtask

   task automatic test_reset();
      frstb = 1'b0;
      req_valid = 0; req_a = '0; req_b = '0; req_uns = 0; rsp_ready = 0;
      repeat (3) @(negedge fclk);
      n_checks++;
      if ({c_valid, c_write, c_addr, c_wdata, rsp_valid, rsp_q, rsp_r, rsp_err, req_ready, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: v=%b w=%b a=%h d=%h rv=%b q=%h r=%h e=%b rdy=%b busy=%b, expected all 0",
                  c_valid, c_write, c_addr, c_wdata, rsp_valid, rsp_q, rsp_r, rsp_err, req_ready, busy);
      end
      frstb = 1'b1;
      repeat (2) @(negedge fclk);
      n_checks++;
      if ({req_ready, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_idle: req_ready=%b busy=%b, expected 1 0", req_ready, busy);
      end
   endtask

   task automatic test_directed();
      logic [31:0] q, r;
      logic        e;
      int          lat, mi;
      busy_len = 33;
      run_op(32'd100, 32'd7, 1'b0, 0, 1'b0, q, r, e, lat);
      n_checks++;
      if ({q, r, e} !== {32'd14, 32'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL signed_100_7: q=%h r=%h e=%b, expected q=0000000e r=00000002 e=0", q, r, e);
      end
      mi = trace_mismatch(32'd100, 32'd7, 1'b0, -1);
      n_checks++;
      if (mi != -1) begin
         n_fail++;
         $display("FAIL trace_100_7: mismatch at %0d of %0d entries, expected canonical sequence", mi, trace.size());
      end
      busy_len = 6;
      run_op(32'hFFFF_FF9C, 32'd7, 1'b0, 0, 1'b0, q, r, e, lat);
      n_checks++;
      if ({q, r, e} !== {32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0}) begin
         n_fail++;
         $display("FAIL signed_m100_7: q=%h r=%h e=%b, expected q=fffffff2 r=fffffffe e=0", q, r, e);
      end
      run_op(32'hFFFF_FFFF, 32'd16, 1'b1, 0, 1'b0, q, r, e, lat);
      n_checks++;
      if ({q, r, e} !== {32'h0FFF_FFFF, 32'h0000_000F, 1'b0}) begin
         n_fail++;
         $display("FAIL unsigned_max_16: q=%h r=%h e=%b, expected q=0fffffff r=0000000f e=0", q, r, e);
      end
      mi = trace_mismatch(32'hFFFF_FFFF, 32'd16, 1'b1, -1);
      n_checks++;
      if (mi != -1) begin
         n_fail++;
         $display("FAIL trace_unsigned: mismatch at %0d of %0d entries, expected CTL 3 then 2", mi, trace.size());
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, q, r, eq, er;
      logic        uns, e;
      int          lat, mi;
      for (int n = 0; n < 10; n++) begin
         a   = $urandom;
         b   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (b == 32'd0) b = 32'd3;
         uns = 1'($urandom_range(0, 1));
         busy_len = $urandom_range(0, 40);
         ref_div(a, b, uns, eq, er);
         run_op(a, b, uns, 0, 1'($urandom_range(0, 1)), q, r, e, lat);
         n_checks++;
         if ({q, r, e} !== {eq, er, 1'b0}) begin
            n_fail++;
            $display("FAIL random_%0d: a=%h b=%h u=%b got q=%h r=%h e=%b, expected q=%h r=%h e=0", n, a, b, uns, q, r, e, eq, er);
         end
         mi = trace_mismatch(a, b, uns, -1);
         n_checks++;
         if (mi != -1) begin
            n_fail++;
            $display("FAIL random_trace_%0d: mismatch at %0d of %0d entries", n, mi, trace.size());
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, q1, r1, q2, r2, eq, er;
      logic        e1, e2;
      int          lat;
      a = $urandom; b = 32'($urandom_range(2, 500));
      busy_len = 8;
      ref_div(a, b, 1'b0, eq, er);
      run_op(a, b, 1'b0, 10, 1'b0, q1, r1, e1, lat);
      run_op(a, b, 1'b0, 10, 1'b0, q2, r2, e2, lat);
      n_checks++;
      if ({q1, r1, e1, q2, r2, e2} !== {eq, er, 1'b0, eq, er, 1'b0}) begin
         n_fail++;
         $display("FAIL back_to_back: q1=%h r1=%h q2=%h r2=%h, expected q=%h r=%h twice", q1, r1, q2, r2, eq, er);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] q, r;
      logic        e;
      int          lat, mi;
      stuck = 1;
      run_op(32'd50, 32'd5, 1'b0, 0, 1'b0, q, r, e, lat);
      stuck = 0;
      busy_cnt = 0;
      n_checks++;
      if ({q, r, e} !== {32'd0, 32'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL timeout_result: q=%h r=%h e=%b, expected q=0 r=0 e=1", q, r, e);
      end
      // Timeout skips the Q/R reads: A, B, CTL, 64 polls, CLR
      mi = (trace.size() == POLL_LIMIT + 4) ? -1 : 9999;
      for (int i = 0; i < trace.size() && mi == -1; i++) begin
         if (i >= 3 && i < 3 + POLL_LIMIT && (trace[i].wr !== 1'b0 || trace[i].addr !== 32'h10)) mi = i;
         if (i == 3 + POLL_LIMIT && (trace[i].wr !== 1'b1 || trace[i].addr !== 32'h10 || trace[i].data !== 32'd0)) mi = i;
      end
      n_checks++;
      if (mi != -1) begin
         n_fail++;
         $display("FAIL timeout_trace: mismatch at %0d, %0d entries, expected %0d polls then CLR", mi, trace.size(), POLL_LIMIT);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] q, r;
      logic        e;
      int          lat, acc_cyc;
      bit          got = 0;
      stuck = 1;
      offer(32'd77, 32'd5, 1'b0, acc_cyc);
      for (int i = 0; i < 300; i++) begin
         @(negedge fclk);
         if (c_valid && !c_write && c_addr == 32'h10) begin got = 1; break; end
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL mid_poll_seen: no poll access within 300 cycles, expected one");
      end
      #1 frstb = 1'b0;
      #1;
      n_checks++;
      if ({c_valid, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL async_reset: c_valid=%b busy=%b, expected 0 0", c_valid, busy);
      end
      repeat (2) @(negedge fclk);
      stuck = 0; busy_cnt = 0;
      frstb = 1'b1;
      busy_len = 4;
      run_op(32'd20, 32'd3, 1'b0, 0, 1'b0, q, r, e, lat);
      n_checks++;
      if ({q, r, e} !== {32'd6, 32'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL after_reset_20_3: q=%h r=%h e=%b, expected q=6 r=2 e=0", q, r, e);
      end
   endtask

   task automatic test_div_zero();
      logic [31:0] q, r;
      logic        e;
      int          lat;
      busy_len = 3;
      run_op(32'd5, 32'd0, 1'b0, 0, 1'b0, q, r, e, lat);
      n_checks++;
      if ({q, r, e} !== {32'hFFFF_FFFF, 32'd5, 1'b0}) begin
         n_fail++;
         $display("FAIL div_zero_result: q=%h r=%h e=%b, expected q=ffffffff r=5 e=0", q, r, e);
      end
`ifdef DIV_ZERO_BYPASS_EN
      n_checks++;
      if ({saw_valid, lat} !== {1'b0, 32'd2}) begin
         n_fail++;
         $display("FAIL div_zero_bypass: c_valid seen=%b latency=%0d, expected 0 and 2", saw_valid, lat);
      end
`else
      n_checks++;
      if (trace_mismatch(32'd5, 32'd0, 1'b0, -1) != -1) begin
         n_fail++;
         $display("FAIL div_zero_trace: %0d entries, expected the normal bus sequence", trace.size());
      end
`endif
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded 1 ms, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      test_div_zero();
      repeat (3) @(negedge fclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
